// File: rtl/secuenciador_filtro.sv
// Time-multiplexed FIR: one shared saturating MAC steps through N_TAPS taps per
// accepted sample, reading coefficients from an external combinational ROM.
module secuenciador_filtro #(
   parameter int N_TAPS = 5,
   parameter int AW     = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               muestra_valida,
   input  logic signed [11:0] muestra_in,
   output logic [AW-1:0]      coef_addr,
   input  logic signed [17:0] coef_in,
   output logic [28:0]        dato_filtro,
   output logic               dato_valido,
   output logic               ocupado,
   output logic               sobrecarga,
   output logic [1:0]         estado
);

   // Strobe protocol: muestra_valida is a one-cycle strobe with no back-pressure.
   // It is accepted only while IDLE; a strobe seen in MAC or DONE is dropped and
   // reported by a one-cycle sobrecarga pulse. dato_valido marks a new dato_filtro.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } estado_t;

   localparam logic [AW-1:0] TAP_LAST = AW'(N_TAPS - 1);

   estado_t            state;
   estado_t            state_next;
   logic signed [11:0] x [N_TAPS];
   logic [28:0]        acc;
   logic [AW-1:0]      tap;

   logic signed [11:0] x_sel;
   logic [29:0]        prod;
   logic [28:0]        prod_sat;
   logic [29:0]        sum;
   logic [28:0]        acc_next;

   // Clamp a 30-bit two's complement value into the 29-bit range.
   function automatic logic [28:0] sat29(input logic [29:0] v);
      logic [28:0] r;
      if (v[29] == v[28]) begin
         r = v[28:0];
      end else if (!v[29]) begin
         r = 29'h0FFF_FFFF;
      end else begin
         r = 29'h1000_0000;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (muestra_valida) begin
               state_next = MAC;
            end
         end
         MAC: begin
            if (tap == TAP_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign estado    = state;
   assign ocupado   = (state != IDLE);
   assign coef_addr = (state == MAC) ? tap : '0;

   // ---------------------------------------------------------------- datapath
   always_comb begin
      x_sel = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         if (tap == AW'(k)) begin
            x_sel = x[k];
         end
      end
   end

   // Full sign extension keeps the 12x18 product exact in 30 bits.
   assign prod     = $signed({{18{x_sel[11]}}, x_sel}) * $signed({{12{coef_in[17]}}, coef_in});
   assign prod_sat = sat29(prod);
   assign sum      = {acc[28], acc} + {prod_sat[28], prod_sat};
   assign acc_next = sat29(sum);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_TAPS; k++) begin
            x[k] <= '0;
         end
         acc         <= '0;
         tap         <= '0;
         dato_filtro <= '0;
         dato_valido <= 1'b0;
         sobrecarga  <= 1'b0;
      end else begin
         dato_valido <= 1'b0;
         sobrecarga  <= 1'b0;
         case (state)
            IDLE: begin
               if (muestra_valida) begin
                  for (int k = N_TAPS - 1; k > 0; k--) begin
                     x[k] <= x[k-1];
                  end
                  x[0] <= muestra_in;
                  acc  <= '0;
                  tap  <= '0;
               end
            end
            MAC: begin
               acc <= acc_next;
               tap <= (tap == TAP_LAST) ? '0 : tap + AW'(1);
               if (muestra_valida) begin
                  sobrecarga <= 1'b1;
               end
            end
            DONE: begin
               dato_filtro <= acc;
               dato_valido <= 1'b1;
               if (muestra_valida) begin
                  sobrecarga <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Directed bench for secuenciador_filtro: an arithmetic FIR model with a result
// queue is compared against the DUT every cycle; literals pin the key scenarios.
module tb_secuenciador_filtro;

   localparam int N_TAPS = 5;
   localparam int AW     = 3;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               muestra_valida;
   logic signed [11:0] muestra_in;
   logic [AW-1:0]      coef_addr;
   logic signed [17:0] coef_in;
   logic [28:0]        dato_filtro;
   logic               dato_valido;
   logic               ocupado;
   logic               sobrecarga;
   logic [1:0]         estado;

   int rom [8];
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int n_valid = 0;
   int n_sobre = 0;

   // behavioural model state
   int          hist [N_TAPS];
   int          busy_left;
   logic [28:0] m_dato;
   logic        m_valid;
   logic        m_sobre;
   logic [28:0] exp_q [$];

   secuenciador_filtro #(.N_TAPS(N_TAPS), .AW(AW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .muestra_valida (muestra_valida),
      .muestra_in     (muestra_in),
      .coef_addr      (coef_addr),
      .coef_in        (coef_in),
      .dato_filtro    (dato_filtro),
      .dato_valido    (dato_valido),
      .ocupado        (ocupado),
      .sobrecarga     (sobrecarga),
      .estado         (estado)
   );

   // ---------------------------------------------------------------- clock/reset
   always #5 clk = ~clk;

   assign coef_in = rom[coef_addr][17:0];

   // ---------------------------------------------------------------- model
   function automatic longint clamp(input longint v);
      if (v > 64'sd268435455) return 64'sd268435455;
      if (v < -64'sd268435456) return -64'sd268435456;
      return v;
   endfunction

   function automatic logic [28:0] fir_model();
      longint acc;
      longint p;
      acc = 0;
      for (int k = 0; k < N_TAPS; k++) begin
         p   = clamp(longint'(hist[k]) * longint'(rom[k]));
         acc = clamp(acc + p);
      end
      return acc[28:0];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_left = 0;
         for (int k = 0; k < N_TAPS; k++) hist[k] = 0;
         m_dato  = '0;
         m_valid = 1'b0;
         m_sobre = 1'b0;
         exp_q.delete();
      end else begin
         m_valid = 1'b0;
         m_sobre = 1'b0;
         if (busy_left > 0) begin
            if (muestra_valida) m_sobre = 1'b1;
            busy_left--;
            if (busy_left == 0) begin
               m_valid = 1'b1;
               if (exp_q.size() > 0) m_dato = exp_q.pop_front();
            end
         end else if (muestra_valida) begin
            for (int k = N_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(muestra_in);
            exp_q.push_back(fir_model());
            busy_left = N_TAPS + 1;
         end
      end
   end

   // ---------------------------------------------------------------- scoreboard
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [AW-1:0] m_addr;
         m_addr = (busy_left >= 2) ? AW'(N_TAPS + 1 - busy_left) : '0;
         check("dato_valido", 64'(dato_valido), 64'(m_valid));
         check("sobrecarga", 64'(sobrecarga), 64'(m_sobre));
         check("ocupado", 64'(ocupado), 64'(busy_left > 0));
         check("coef_addr", 64'(coef_addr), 64'(m_addr));
         check("dato_filtro", 64'(dato_filtro), 64'(m_dato));
         if (dato_valido) n_valid++;
         if (sobrecarga) n_sobre++;
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic set_rom(input int c0, input int c1, input int c_rest);
      rom[0] = c0;
      rom[1] = c1;
      for (int k = 2; k < 8; k++) rom[k] = c_rest;
   endtask

   task automatic send(input logic signed [11:0] s);
      @(negedge clk);
      muestra_valida = 1'b1;
      muestra_in     = s;
      @(negedge clk);
      muestra_valida = 1'b0;
      muestra_in     = '0;
   endtask

   // Entered at the negedge after the accepting edge (or later, with start_edges).
   task automatic wait_result(input logic [28:0] exp, input bit lit, input int start_edges,
                              input string nm);
      int edges;
      bit got;
      edges = start_edges;
      got   = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         edges++;
         if (dato_valido) got = 1'b1;
      end
      check({nm, "_latency"}, 64'(got ? edges : 99), 64'(N_TAPS + 1));
      if (lit) check({nm, "_value"}, 64'(dato_filtro), 64'(exp));
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int s0;
      int v0;
      int s1;
      reset_n        = 1'b0;
      muestra_valida = 1'b0;
      muestra_in     = '0;
      set_rom(1024, 512, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      repeat (10) @(negedge clk);
      check("idle_dato_filtro", 64'(dato_filtro), 64'h0);
      check("idle_coef_addr", 64'(coef_addr), 64'h0);
      check("idle_ocupado", 64'(ocupado), 64'h0);
      check("idle_dato_valido", 64'(dato_valido), 64'h0);
      check("idle_sobrecarga", 64'(sobrecarga), 64'h0);

      // impulse response
      send(12'sd256); wait_result(29'h0040000, 1'b1, 0, "impulse0");
      send(12'sd0);   wait_result(29'h0020000, 1'b1, 0, "impulse1");
      send(12'sd0);   wait_result(29'h0, 1'b1, 0, "impulse2");
      send(12'sd0);   wait_result(29'h0, 1'b1, 0, "impulse3");

      // saturation, both rails
      set_rom(131071, 131071, 131071);
      for (int i = 0; i < N_TAPS; i++) begin
         send(12'h7FF); wait_result(29'h0, 1'b0, 0, "sat_pos_fill");
      end
      check("sat_pos_value", 64'(dato_filtro), 64'h0FFF_FFFF);
      for (int i = 0; i < N_TAPS; i++) begin
         send(12'h800); wait_result(29'h0, 1'b0, 0, "sat_neg_fill");
      end
      check("sat_neg_value", 64'(dato_filtro), 64'h1000_0000);

      // corner product -2048 * -131072
      set_rom(1024, 512, 0);
      for (int i = 0; i < N_TAPS; i++) begin
         send(12'sd0); wait_result(29'h0, 1'b0, 0, "corner_fill");
      end
      set_rom(-131072, 0, 0);
      send(12'h800); wait_result(29'h0FFF_FFFF, 1'b1, 0, "corner");

      // overrun: strobes at E0 and E3
      set_rom(1024, 512, 0);
      for (int i = 0; i < N_TAPS; i++) begin
         send(12'sd0); wait_result(29'h0, 1'b0, 0, "overrun_fill");
      end
      @(negedge clk);
      muestra_valida = 1'b1;
      muestra_in     = 12'sd256;
      @(negedge clk);
      muestra_valida = 1'b0;
      muestra_in     = '0;
      s0 = n_sobre;
      v0 = n_valid;
      repeat (2) @(negedge clk);
      muestra_valida = 1'b1;
      muestra_in     = 12'sd100;
      @(negedge clk);
      muestra_valida = 1'b0;
      muestra_in     = '0;
      wait_result(29'h0040000, 1'b1, 3, "overrun");

      // strobe in the dato_valido cycle is accepted
      muestra_valida = 1'b1;
      muestra_in     = 12'sd0;
      @(negedge clk);
      muestra_valida = 1'b0;
      check("overrun_sobre_count", 64'(n_sobre - s0), 64'd1);
      check("overrun_valid_count", 64'(n_valid - v0), 64'd1);
      s1 = n_sobre;
      wait_result(29'h0020000, 1'b1, 0, "coincident");
      @(negedge clk);
      check("coincident_sobre_count", 64'(n_sobre - s1), 64'd0);

      // reset mid-MAC
      send(12'sd300);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      v0 = n_valid;
      repeat (10) @(negedge clk);
      check("reset_valid_count", 64'(n_valid - v0), 64'd0);
      check("reset_dato_filtro", 64'(dato_filtro), 64'h0);
      check("reset_ocupado", 64'(ocupado), 64'h0);
      send(12'sd256); wait_result(29'h0040000, 1'b1, 0, "post_reset0");
      send(12'sd0);   wait_result(29'h0020000, 1'b1, 0, "post_reset1");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
